spectro_fifo_writer: RTL and testbench
======================================

# spectro_fifo_writer

Write side of the spectrometer sample FIFO. It captures per-pixel ADC samples from the linear-sensor readout, frames them, and pushes them into the FIFO with FIFO_WR, respecting FIFO_FULL. Each word carries a start-of-frame flag so the read side can resynchronise. Frames that cannot be stored whole are dropped and counted.

## Interface
Parameters:
- DATA_W, 10: ADC sample width.
- PIXELS, 3648: samples per complete frame (≥2).
- ERR_W, 16: width of the drop counter.

Ports:
- CLK  in  1  clock.
- RST  in  1  reset, synchronous, active-high.
- adcData  in  DATA_W  ADC sample, valid when adcValid=1.
- adcValid  in  1  one-cycle strobe per sample; consecutive strobes are ≥2 CLK apart.
- frameStart  in  1  one-cycle pulse; the next adcValid is pixel 0.
- FIFO_FULL  in  1  FIFO full flag; already reflects any write issued in the previous cycle.
- FIFO_WR  out  1  write strobe, one cycle per word.
- fifoData  out  DATA_W+1  {sof, sample}; bit DATA_W = 1 only on pixel 0.
- frameDone  out  1  one-cycle pulse with the FIFO_WR of pixel PIXELS-1.
- frameDropped  out  1  one-cycle pulse per dropped or truncated frame.
- dropCount  out  ERR_W  saturating count of frameDropped events.
- busy  out  1  high while in CAPTURE.

## Operation
- States: IDLE, CAPTURE, DISCARD. Pixel counter pix in 0..PIXELS-1.
- IDLE: adcValid is ignored. On frameStart with FIFO_FULL=0: go to CAPTURE and set pix=0. On frameStart with FIFO_FULL=1: go to DISCARD and pulse frameDropped.
- CAPTURE, adcValid with FIFO_FULL=0: write {pix==0, adcData} and increment pix. At pix==PIXELS-1, pulse frameDone and go to IDLE.
- CAPTURE, adcValid with FIFO_FULL=1: the sample is lost and nothing is written. Pulse frameDropped and go to DISCARD.
- CAPTURE, frameStart before PIXELS samples (runt frame): pulse frameDropped, then restart per the IDLE rules, including the FIFO_FULL check. The partial words stay in the FIFO; the next sof marks the resync point.
- DISCARD: adcValid is ignored. frameStart is handled as in IDLE.
- frameStart and adcValid in the same cycle: frameStart wins and the sample is ignored.
- dropCount increments on every frameDropped pulse and saturates at 2^ERR_W−1.
- Reset, including mid-frame: state IDLE, pix=0, FIFO_WR=0, fifoData=0, frameDone=0, frameDropped=0, dropCount=0, busy=0. Words already written remain in the FIFO.

## Timing
- All outputs are registered. FIFO_WR and fifoData appear the cycle after the adcValid cycle: 1-cycle latency.
- FIFO_FULL is sampled only in the adcValid or frameStart cycle.
- frameDone is coincident with the last FIFO_WR.
- frameDropped appears the cycle after the triggering event.
- dropCount updates in the same cycle as frameDropped.
- busy rises the cycle after an accepted frameStart. It falls with frameDone, with the truncation frameDropped, or with a rejected restart.
- fifoData holds its last value when FIFO_WR=0.

## Structure
- Package spectro_pkg holds:
  - the state enum (IDLE, CAPTURE, DISCARD);
  - default DATA_W and PIXELS;
  - the SOF bit position (DATA_W);
  - a typedef for the FIFO word.
  The read side imports the same package.
- One sub-module, sat_counter (parameterised width, inc, clear, saturating), implements dropCount.
- The FSM, pixel counter and output registers live in the top module.

## Test plan
Simulation uses PIXELS=8 and ERR_W=4.
- Normal frame: frameStart, then samples 0x001..0x008 with FULL=0 → 8 FIFO_WR pulses. The first word is 0x401, the rest are 0x002..0x008. frameDone is coincident with the 8th write. dropCount=0.
- Full at start: FULL=1 at frameStart → no FIFO_WR for the following 8 samples, one frameDropped, dropCount=1, busy stays 0.
- Full mid-frame: FULL rises before pixel 3 → 3 writes (0x401, 0x002, 0x003), one frameDropped, then no writes until the next frameStart.
- Runt and collision: frameStart after 5 samples, coincident with an adcValid → frameDropped, dropCount+1, the coincident sample is not written, and the next sample is written with sof=1.
- Saturation: 17 full-at-start frames → dropCount=15 and it holds at 15.
- Reset mid-frame: RST after 4 writes → all outputs 0 the next cycle. adcValid produces no writes until frameStart, and the following frame starts with a sof word.

Source files
------------

// File: rtl/spectro_pkg.sv
// Shared types and defaults for the spectrometer sample FIFO (write and read sides).
package spectro_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DISCARD = 2'd2
    } state_t;

    localparam int DEFAULT_DATA_W = 10;
    localparam int DEFAULT_PIXELS = 3648;
    localparam int SOF_BIT        = DEFAULT_DATA_W;

    typedef struct packed {
        logic                      sof;
        logic [DEFAULT_DATA_W-1:0] sample;
    } fifo_word_t;

    function automatic fifo_word_t make_word(input logic sof, input logic [DEFAULT_DATA_W-1:0] sample);
        fifo_word_t w;
        w.sof    = sof;
        w.sample = sample;
        return w;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
// Count updates the cycle after inc; clear has priority over inc.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         CLK,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge CLK) begin
        if (clear) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/spectro_fifo_writer.sv
// Frames ADC pixel samples into {sof, sample} FIFO words; 1-cycle registered latency.
// A full FIFO at frame start or mid-frame drops the rest of that frame and counts it.
module spectro_fifo_writer
    import spectro_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int PIXELS = DEFAULT_PIXELS,
    parameter int ERR_W  = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [DATA_W-1:0] adcData,
    input  logic              adcValid,
    input  logic              frameStart,
    input  logic              FIFO_FULL,
    output logic              FIFO_WR,
    output logic [DATA_W:0]   fifoData,
    output logic              frameDone,
    output logic              frameDropped,
    output logic [ERR_W-1:0]  dropCount,
    output logic              busy
);

    localparam int PIX_W = (PIXELS > 1) ? $clog2(PIXELS) : 1;
    localparam logic [PIX_W-1:0] LAST_PIX = PIX_W'(PIXELS - 1);

    state_t           state, state_n;
    logic [PIX_W-1:0] pix, pix_n;
    logic             wr_n, done_n, drop_n;
    logic [DATA_W:0]  data_n;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state        <= IDLE;
            pix          <= '0;
            FIFO_WR      <= 1'b0;
            fifoData     <= '0;
            frameDone    <= 1'b0;
            frameDropped <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state        <= state_n;
            pix          <= pix_n;
            FIFO_WR      <= wr_n;
            fifoData     <= data_n;
            frameDone    <= done_n;
            frameDropped <= drop_n;
            busy         <= (state_n == CAPTURE);
        end
    end

    always_comb begin
        state_n = state;
        pix_n   = pix;
        wr_n    = 1'b0;
        data_n  = fifoData;
        done_n  = 1'b0;
        drop_n  = 1'b0;

        // frameStart outranks a coincident sample; an open frame becomes a runt
        if (frameStart) begin
            if (state == CAPTURE) begin
                drop_n = 1'b1;
            end
            if (FIFO_FULL) begin
                state_n = DISCARD;
                drop_n  = 1'b1;
            end else begin
                state_n = CAPTURE;
                pix_n   = '0;
            end
        end else if (adcValid && (state == CAPTURE)) begin
            if (FIFO_FULL) begin
                state_n = DISCARD;
                drop_n  = 1'b1;
            end else begin
                wr_n   = 1'b1;
                data_n = {(pix == '0), adcData};
                if (pix == LAST_PIX) begin
                    done_n  = 1'b1;
                    state_n = IDLE;
                    pix_n   = '0;
                end else begin
                    pix_n = pix + 1'b1;
                end
            end
        end
    end

    sat_counter #(
        .W(ERR_W)
    ) u_drop_cnt (
        .CLK  (CLK),
        .clear(RST),
        .inc  (drop_n),
        .count(dropCount)
    );

endmodule

// File: tb/tb_spectro_fifo_writer.sv
// Directed bench for spectro_fifo_writer with PIXELS=8, ERR_W=4.
module tb_spectro_fifo_writer;

    localparam int DATA_W = 10;
    localparam int PIXELS = 8;
    localparam int ERR_W  = 4;

    logic              CLK = 1'b0;
    logic              RST = 1'b1;
    logic [DATA_W-1:0] adcData = '0;
    logic              adcValid = 1'b0;
    logic              frameStart = 1'b0;
    logic              FIFO_FULL = 1'b0;
    logic              FIFO_WR;
    logic [DATA_W:0]   fifoData;
    logic              frameDone;
    logic              frameDropped;
    logic [ERR_W-1:0]  dropCount;
    logic              busy;

    spectro_fifo_writer #(
        .DATA_W(DATA_W),
        .PIXELS(PIXELS),
        .ERR_W (ERR_W)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .adcData     (adcData),
        .adcValid    (adcValid),
        .frameStart  (frameStart),
        .FIFO_FULL   (FIFO_FULL),
        .FIFO_WR     (FIFO_WR),
        .fifoData    (fifoData),
        .frameDone   (frameDone),
        .frameDropped(frameDropped),
        .dropCount   (dropCount),
        .busy        (busy)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;

    logic [DATA_W:0] wr_q[$];
    int n_done, n_drop, n_busy, done_idx;

    // Outputs are observed on the falling edge, away from the active edge.
    always @(negedge CLK) begin
        if (FIFO_WR) wr_q.push_back(fifoData);
        if (frameDone) done_idx = FIFO_WR ? (wr_q.size() - 1) : -1;
        n_done += int'(frameDone);
        n_drop += int'(frameDropped);
        n_busy += int'(busy);
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic clr_mon();
        wr_q.delete();
        n_done   = 0;
        n_drop   = 0;
        n_busy   = 0;
        done_idx = -2;
    endtask

    task automatic start_frame(input logic full);
        frameStart = 1'b1;
        FIFO_FULL  = full;
        cyc(1);
        frameStart = 1'b0;
        FIFO_FULL  = 1'b0;
        cyc(1);
    endtask

    task automatic sample(input logic [DATA_W-1:0] d, input logic full);
        adcData   = d;
        adcValid  = 1'b1;
        FIFO_FULL = full;
        cyc(1);
        adcValid  = 1'b0;
        FIFO_FULL = 1'b0;
        cyc(1);
    endtask

    task automatic chk_idle_outputs(input string pfx);
        chk({pfx, "_wr"},   32'(FIFO_WR), 32'h0);
        chk({pfx, "_data"}, 32'(fifoData), 32'h0);
        chk({pfx, "_done"}, 32'(frameDone), 32'h0);
        chk({pfx, "_drop"}, 32'(frameDropped), 32'h0);
        chk({pfx, "_cnt"},  32'(dropCount), 32'h0);
        chk({pfx, "_busy"}, 32'(busy), 32'h0);
    endtask

    initial begin
        clr_mon();

        // Reset state
        cyc(3);
        chk_idle_outputs("rst");
        RST = 1'b0;
        cyc(1);

        // Normal frame, with explicit latency check on pixel 0
        clr_mon();
        start_frame(1'b0);
        chk("norm_busy_up", 32'(busy), 32'h1);
        adcData  = 10'h001;
        adcValid = 1'b1;
        cyc(1);
        adcValid = 1'b0;
        chk("norm_lat_wr", 32'(FIFO_WR), 32'h1);
        chk("norm_lat_data", 32'(fifoData), 32'h401);
        cyc(1);
        chk("norm_wr_pulse", 32'(FIFO_WR), 32'h0);
        chk("norm_data_hold", 32'(fifoData), 32'h401);
        for (int i = 2; i <= 8; i++) sample(10'(i), 1'b0);
        chk("norm_nwr", 32'(wr_q.size()), 32'd8);
        for (int i = 0; i < 8 && i < wr_q.size(); i++)
            chk($sformatf("norm_word%0d", i), 32'(wr_q[i]), (i == 0) ? 32'h401 : 32'(i + 1));
        chk("norm_ndone", 32'(n_done), 32'd1);
        chk("norm_done_idx", 32'(done_idx), 32'd7);
        chk("norm_cnt", 32'(dropCount), 32'd0);
        chk("norm_busy_down", 32'(busy), 32'h0);

        // Full at frame start
        clr_mon();
        start_frame(1'b1);
        for (int i = 1; i <= 8; i++) sample(10'(i), 1'b0);
        chk("fstart_nwr", 32'(wr_q.size()), 32'd0);
        chk("fstart_ndrop", 32'(n_drop), 32'd1);
        chk("fstart_cnt", 32'(dropCount), 32'd1);
        chk("fstart_busy", 32'(n_busy), 32'd0);

        // Full mid-frame before pixel 3
        clr_mon();
        start_frame(1'b0);
        for (int i = 1; i <= 3; i++) sample(10'(i), 1'b0);
        sample(10'h004, 1'b1);
        for (int i = 5; i <= 8; i++) sample(10'(i), 1'b0);
        chk("fmid_nwr", 32'(wr_q.size()), 32'd3);
        if (wr_q.size() >= 3) begin
            chk("fmid_w0", 32'(wr_q[0]), 32'h401);
            chk("fmid_w1", 32'(wr_q[1]), 32'h002);
            chk("fmid_w2", 32'(wr_q[2]), 32'h003);
        end
        chk("fmid_ndrop", 32'(n_drop), 32'd1);
        chk("fmid_ndone", 32'(n_done), 32'd0);
        chk("fmid_cnt", 32'(dropCount), 32'd2);
        chk("fmid_busy", 32'(busy), 32'h0);

        // Runt frame restarted by frameStart coincident with a sample
        clr_mon();
        start_frame(1'b0);
        for (int i = 1; i <= 5; i++) sample(10'(i), 1'b0);
        frameStart = 1'b1;
        adcValid   = 1'b1;
        adcData    = 10'h006;
        cyc(1);
        frameStart = 1'b0;
        adcValid   = 1'b0;
        chk("runt_drop_pulse", 32'(frameDropped), 32'h1);
        chk("runt_no_wr", 32'(FIFO_WR), 32'h0);
        chk("runt_busy", 32'(busy), 32'h1);
        cyc(1);
        sample(10'h3AA, 1'b0);
        for (int i = 2; i <= 8; i++) sample(10'(i), 1'b0);
        chk("runt_nwr", 32'(wr_q.size()), 32'd13);
        if (wr_q.size() >= 6) chk("runt_sof_word", 32'(wr_q[5]), 32'h7AA);
        chk("runt_ndrop", 32'(n_drop), 32'd1);
        chk("runt_ndone", 32'(n_done), 32'd1);
        chk("runt_cnt", 32'(dropCount), 32'd3);

        // Saturation from a clean counter
        RST = 1'b1;
        cyc(1);
        RST = 1'b0;
        clr_mon();
        for (int i = 0; i < 14; i++) start_frame(1'b1);
        chk("sat_cnt14", 32'(dropCount), 32'd14);
        for (int i = 0; i < 3; i++) start_frame(1'b1);
        chk("sat_ndrop", 32'(n_drop), 32'd17);
        chk("sat_cnt_hold", 32'(dropCount), 32'd15);

        // Reset mid-frame
        start_frame(1'b0);
        for (int i = 1; i <= 4; i++) sample(10'(i), 1'b0);
        RST = 1'b1;
        cyc(1);
        chk_idle_outputs("rmid");
        RST = 1'b0;
        cyc(1);
        clr_mon();
        for (int i = 5; i <= 7; i++) sample(10'(i), 1'b0);
        chk("rmid_nwr_after", 32'(wr_q.size()), 32'd0);
        start_frame(1'b0);
        sample(10'h055, 1'b0);
        chk("rmid_nwr_new", 32'(wr_q.size()), 32'd1);
        if (wr_q.size() >= 1) chk("rmid_sof_word", 32'(wr_q[0]), 32'h455);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
